sram_arb: RTL and testbench

Parametrised external-SRAM arbiter for the ULA memory subsystem. It takes NCH independent read/write requesters: screen fetch, CPU, memory initialiser, and future DMA. It grants one access at a time and drives the shared va/vd bus with n_vrd/n_vwr strobes. It returns read data to the granted channel. It replaces ad-hoc strobe and address muxing with a uniform req/ack/rvalid handshake, fixed or round-robin priority, and bus turnaround handling.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_arb_if.sv | 32 +++
 rtl/sram_arb_rr_pick.sv | 48 ++++
 rtl/sram_arb.sv | 163 ++++++++++++++++
 tb/tb_sram_arb.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the external-SRAM arbiter: FSM states, channel index and
// access-cycle counter widths.
package sram_arb_pkg;

  localparam int ARB_MAX_CH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_TURN
  } arb_state_t;

  typedef logic [$clog2(ARB_MAX_CH)-1:0] ch_idx_t;
  typedef logic [2:0]                    cnt_t;

endpackage

// File: rtl/sram_arb_if.sv
// Requester handshake plus SRAM pin bundle. The arbiter uses the slave view;
// requesters and the SRAM device see the master view.
interface sram_arb_if #(
  parameter int NCH = 4,
  parameter int AW  = 19,
  parameter int DW  = 8
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [NCH-1:0]    ack;
  logic [NCH-1:0]    rvalid;
  logic [DW-1:0]     rdata;
  logic              idle;
  logic [AW-1:0]     va;
  logic [DW-1:0]     vd_out;
  logic              vd_oe;
  logic [DW-1:0]     vd_in;
  logic              n_vrd;
  logic              n_vwr;

  modport slave (
    input  req, we, addr, wdata, vd_in,
    output ack, rvalid, rdata, idle, va, vd_out, vd_oe, n_vrd, n_vwr
  );

  modport master (
    output req, we, addr, wdata, vd_in,
    input  ack, rvalid, rdata, idle, va, vd_out, vd_oe, n_vrd, n_vwr
  );
endinterface

// File: rtl/sram_arb_rr_pick.sv
// Combinational winner selection: channel 0 always first, then either a
// round-robin search over 1..NCH-1 starting after i_ptr, or lowest index.
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] i_req,
  input  ch_idx_t        i_ptr,
  input  logic           i_rr_mode,
  output logic [NCH-1:0] o_grant,
  output ch_idx_t        o_idx,
  output logic           o_valid
);

  always_comb begin
    int c;
    // NOTE: every output gets a default before any branch so no latch is inferred.
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    c       = 0;
    if (i_req[0]) begin
      o_grant[0] = 1'b1;
      o_valid    = 1'b1;
    end else if (i_rr_mode) begin
      // Pointer lives in 1..NCH-1, so wrapping subtracts NCH-1, never NCH.
      for (int k = 1; k < NCH; k++) begin
        c = int'(i_ptr) + k;
        if (c >= NCH) c = c - (NCH - 1);
        if (!o_valid && i_req[c]) begin
          o_grant[c] = 1'b1;
          o_idx      = ch_idx_t'(c);
          o_valid    = 1'b1;
        end
      end
    end else begin
      for (int i = 1; i < NCH; i++) begin
        if (!o_valid && i_req[i]) begin
          o_grant[i] = 1'b1;
          o_idx      = ch_idx_t'(i);
          o_valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_arb.sv
// External-SRAM arbiter: grants one requester at a time, sequences n_vrd/n_vwr
// strobes over ACC_CYCLES clocks and inserts a turnaround after write->read.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int AW         = 19,
  parameter int DW         = 8,
  parameter int ACC_CYCLES = 2,
  parameter int RR_MODE    = 1
) (
  input logic       clk28,
  input logic       rst_n,
  sram_arb_if.slave bus
);

  localparam cnt_t LAST = cnt_t'(ACC_CYCLES - 1);

  arb_state_t     r_state, w_state_nxt;
  cnt_t           r_cnt, w_cnt_nxt;
  ch_idx_t        r_ptr, w_idx;
  logic [NCH-1:0] w_grant, r_ch_oh, w_nx_ch_oh;
  logic           w_valid, w_latch, w_start, w_capture;
  logic           r_we, w_sel_we, w_nx_we;
  logic [AW-1:0]  r_addr, w_sel_addr, w_nx_addr;
  logic [DW-1:0]  r_wdata, w_sel_wdata, w_nx_wdata;

  logic [NCH-1:0] r_ack, r_rvalid;
  logic [DW-1:0]  r_rdata, r_vd_out;
  logic [AW-1:0]  r_va;
  logic           r_idle, r_vd_oe, r_n_vrd, r_n_vwr;

  rr_pick #(.NCH(NCH)) u_pick (
    .i_req     (bus.req),
    .i_ptr     (r_ptr),
    .i_rr_mode (RR_MODE != 0),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_valid   (w_valid)
  );

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant[i]) begin
        w_sel_we    = bus.we[i];
        w_sel_addr  = bus.addr[i*AW +: AW];
        w_sel_wdata = bus.wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_valid) begin
          w_latch     = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = ARB_ACCESS;
          w_cnt_nxt   = '0;
        end
      end
      ARB_ACCESS: begin
        if (r_cnt != LAST) begin
          w_cnt_nxt = r_cnt + cnt_t'(1);
        end else begin
          w_capture = !r_we;
          w_cnt_nxt = '0;
          if (!w_valid) begin
            w_state_nxt = ARB_IDLE;
          end else if (r_we && !w_sel_we) begin
            // Winner is latched now but only acked after the bus has turned.
            w_latch     = 1'b1;
            w_state_nxt = ARB_TURN;
          end else begin
            w_latch     = 1'b1;
            w_start     = 1'b1;
            w_state_nxt = ARB_ACCESS;
          end
        end
      end
      ARB_TURN: begin
        w_start     = 1'b1;
        w_state_nxt = ARB_ACCESS;
        w_cnt_nxt   = '0;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase

    w_nx_ch_oh = w_latch ? w_grant     : r_ch_oh;
    w_nx_we    = w_latch ? w_sel_we    : r_we;
    w_nx_addr  = w_latch ? w_sel_addr  : r_addr;
    w_nx_wdata = w_latch ? w_sel_wdata : r_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ARB_IDLE;
      r_cnt    <= '0;
      r_ptr    <= ch_idx_t'(NCH - 1);
      r_ch_oh  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_ack    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_va     <= '0;
      r_vd_out <= '0;
      r_idle   <= 1'b1;
      r_vd_oe  <= 1'b0;
      r_n_vrd  <= 1'b1;
      r_n_vwr  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ch_oh  <= w_nx_ch_oh;
      r_we     <= w_nx_we;
      r_addr   <= w_nx_addr;
      r_wdata  <= w_nx_wdata;
      if (w_latch && !w_grant[0]) r_ptr <= w_idx;

      r_ack    <= w_start ? w_nx_ch_oh : '0;
      r_rvalid <= w_capture ? r_ch_oh : '0;
      if (w_capture) r_rdata <= bus.vd_in;
      if (w_start) begin
        r_va     <= w_nx_addr;
        r_vd_out <= w_nx_wdata;
      end
      r_idle <= (w_state_nxt == ARB_IDLE);
      // Outputs are computed for the upcoming cycle; cnt=0 of a write is setup.
      if (w_state_nxt == ARB_ACCESS) begin
        r_n_vrd <= w_nx_we;
        r_vd_oe <= w_nx_we;
        r_n_vwr <= !(w_nx_we && (w_cnt_nxt != '0));
      end else begin
        r_n_vrd <= 1'b1;
        r_vd_oe <= 1'b0;
        r_n_vwr <= 1'b1;
      end
    end
  end

  assign bus.ack    = r_ack;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;
  assign bus.idle   = r_idle;
  assign bus.va     = r_va;
  assign bus.vd_out = r_vd_out;
  assign bus.vd_oe  = r_vd_oe;
  assign bus.n_vrd  = r_n_vrd;
  assign bus.n_vwr  = r_n_vwr;

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: a round-robin instance with an SRAM model and a
// fixed-priority instance, both with ACC_CYCLES=2.
module tb_sram_arb;

  localparam int NCH = 4;
  localparam int AW  = 19;
  localparam int DW  = 8;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk28 = ~clk28;

  sram_arb_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus   ();
  sram_arb_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus_f ();

  sram_arb #(.NCH(NCH), .AW(AW), .DW(DW), .ACC_CYCLES(2), .RR_MODE(1)) u_dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  sram_arb #(.NCH(NCH), .AW(AW), .DW(DW), .ACC_CYCLES(2), .RR_MODE(0)) u_fix (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus_f.slave)
  );

  assign bus_f.vd_in = '0;

  // SRAM model: writes land and reads are presented mid-cycle.
  logic [7:0] mem [logic [18:0]];
  always @(negedge clk28) begin
    if (!bus.n_vwr && bus.vd_oe) mem[bus.va] = bus.vd_out;
    bus.vd_in = (!bus.n_vrd && mem.exists(bus.va)) ? mem[bus.va] : 8'h00;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk28);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic r, input logic w,
                        input logic [18:0] a, input logic [7:0] d);
    bus.req[ch]            = r;
    bus.we[ch]             = w;
    bus.addr[ch*AW +: AW]  = a;
    bus.wdata[ch*DW +: DW] = d;
  endtask

  int         rr_order [3] = '{1, 2, 3};
  logic [3:0] e;

  initial begin
    bus.req   = '0; bus.we   = '0; bus.addr   = '0; bus.wdata   = '0;
    bus_f.req = '0; bus_f.we = '0; bus_f.addr = '0; bus_f.wdata = '0;
    mem[19'h1A5A5] = 8'h3C;

    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // Reset state, held with no requests
    check("rst_n_vrd", bus.n_vrd, 1);
    check("rst_n_vwr", bus.n_vwr, 1);
    check("rst_vd_oe", bus.vd_oe, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_va", bus.va, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_ack", bus.ack, 0);
      check("rst_idle", bus.idle, 1);
      check("rst_rvalid", bus.rvalid, 0);
    end

    // Single read: ch2 @0x1A5A5
    set_ch(2, 1, 0, 19'h1A5A5, 8'h00);
    tick();
    check("rd_ack", bus.ack, 4'b0100);
    check("rd_n_vrd_c0", bus.n_vrd, 0);
    check("rd_va", bus.va, 32'h1A5A5);
    check("rd_idle", bus.idle, 0);
    check("rd_vd_oe", bus.vd_oe, 0);
    tick();
    set_ch(2, 0, 0, 19'h1A5A5, 8'h00);
    check("rd_n_vrd_c1", bus.n_vrd, 0);
    check("rd_ack_pulse", bus.ack, 0);
    tick();
    check("rd_rvalid", bus.rvalid, 4'b0100);
    check("rd_rdata", bus.rdata, 8'h3C);
    check("rd_n_vrd_end", bus.n_vrd, 1);
    check("rd_idle_end", bus.idle, 1);
    tick();
    check("rd_rvalid_pulse", bus.rvalid, 0);
    check("rd_rdata_hold", bus.rdata, 8'h3C);

    // Write ch1 then read ch3 at the same address
    set_ch(1, 1, 1, 19'h00100, 8'h55);
    tick();
    set_ch(3, 1, 0, 19'h00100, 8'h00);
    check("wr_ack", bus.ack, 4'b0010);
    check("wr_vd_oe_c0", bus.vd_oe, 1);
    check("wr_n_vwr_c0", bus.n_vwr, 1);
    check("wr_vd_out", bus.vd_out, 8'h55);
    tick();
    set_ch(1, 0, 1, 19'h00100, 8'h55);
    check("wr_n_vwr_c1", bus.n_vwr, 0);
    check("wr_vd_oe_c1", bus.vd_oe, 1);
    tick();
    check("turn_vd_oe", bus.vd_oe, 0);
    check("turn_n_vwr", bus.n_vwr, 1);
    check("turn_n_vrd", bus.n_vrd, 1);
    check("turn_ack", bus.ack, 0);
    check("turn_idle", bus.idle, 0);
    check("turn_va", bus.va, 32'h00100);
    tick();
    check("wrrd_ack", bus.ack, 4'b1000);
    check("wrrd_n_vrd", bus.n_vrd, 0);
    tick();
    set_ch(3, 0, 0, 19'h00100, 8'h00);
    tick();
    check("wrrd_rvalid", bus.rvalid, 4'b1000);
    check("wrrd_rdata", bus.rdata, 8'h55);
    tick();

    // Round-robin among ch1..3, then a ch0 injection
    set_ch(1, 1, 0, 19'h00011, 8'h00);
    set_ch(2, 1, 0, 19'h00022, 8'h00);
    set_ch(3, 1, 0, 19'h00033, 8'h00);
    for (int k = 0; k < 12; k++) begin
      tick();
      e = (k % 2 == 0) ? (4'b0001 << rr_order[(k / 2) % 3]) : 4'b0000;
      check("rr_ack", bus.ack, e);
      check("rr_busy", bus.idle, 0);
    end
    set_ch(0, 1, 0, 19'h00000, 8'h00);
    tick();
    check("rr_ch0_ack", bus.ack, 4'b0001);
    tick();
    set_ch(0, 0, 0, 19'h00000, 8'h00);
    tick();
    check("rr_resume1", bus.ack, 4'b0010);
    tick();
    tick();
    check("rr_resume2", bus.ack, 4'b0100);
    tick();
    set_ch(1, 0, 0, 19'h00011, 8'h00);
    set_ch(2, 0, 0, 19'h00022, 8'h00);
    set_ch(3, 0, 0, 19'h00033, 8'h00);
    tick();
    check("rr_idle", bus.idle, 1);
    check("rr_no_ack", bus.ack, 0);
    tick();

    // Fixed priority: ch1 always beats ch3
    bus_f.req[1] = 1'b1;
    bus_f.req[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("fix_ack", bus_f.ack, (k % 2 == 1) ? 4'b0010 : 4'b0000);
    end
    bus_f.req[1] = 1'b0;
    tick();
    check("fix_ch3_ack", bus_f.ack, 4'b1000);
    tick();
    bus_f.req[3] = 1'b0;
    tick();
    check("fix_idle", bus_f.idle, 1);

    // Reset during the strobed cycle of a write
    set_ch(1, 1, 1, 19'h00200, 8'hA7);
    tick();
    check("mid_ack", bus.ack, 4'b0010);
    tick();
    check("mid_n_vwr_pre", bus.n_vwr, 0);
    rst_n = 1'b0;
    #1;
    check("mid_n_vwr", bus.n_vwr, 1);
    check("mid_vd_oe", bus.vd_oe, 0);
    check("mid_idle", bus.idle, 1);
    check("mid_va", bus.va, 0);
    check("mid_rdata", bus.rdata, 0);
    set_ch(1, 0, 0, 19'h00000, 8'h00);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_ack", bus.ack, 0);
      check("post_rvalid", bus.rvalid, 0);
    end
    check("mid_no_write", mem.exists(19'h00200), 0);

    // Normal operation after reset
    set_ch(2, 1, 0, 19'h1A5A5, 8'h00);
    tick();
    check("post_rd_ack", bus.ack, 4'b0100);
    tick();
    set_ch(2, 0, 0, 19'h1A5A5, 8'h00);
    tick();
    check("post_rd_rvalid", bus.rvalid, 4'b0100);
    check("post_rd_rdata", bus.rdata, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
